// File: rtl/hit_resolver.sv
// Defender-side hit resolution: range check, one connect per attack, block/hit stun, health and KO.
// Optional combo counter is built when HIT_RESOLVER_COMBO_EN is defined; otherwise combo_count is tied to 0.
module hit_resolver #(
  parameter int unsigned SPRITE_W    = 64,
  parameter int unsigned REACH_N     = 32,
  parameter int unsigned REACH_D     = 40,
  parameter int unsigned HITSTUN_N   = 12,
  parameter int unsigned HITSTUN_D   = 15,
  parameter int unsigned BLOCKSTUN_N = 8,
  parameter int unsigned BLOCKSTUN_D = 10,
  parameter int unsigned HEALTH_INIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_active,
  input  logic [3:0] atk_state,
  input  logic       atk_dir,
  input  logic [9:0] atk_x,
  input  logic [9:0] def_x,
  input  logic [3:0] def_state,
  output logic       hit_pulse,
  output logic       block_pulse,
  output logic [1:0] def_stun,
  output logic [4:0] stun_left,
  output logic [1:0] health,
  output logic       ko,
  output logic [3:0] combo_count
);

  localparam int unsigned XW    = 10;
  localparam int unsigned GW    = 11;
  localparam int unsigned STUNW = 5;
  localparam int unsigned HPW   = 2;
  localparam int unsigned CW    = 4;

  localparam logic [3:0] ATK_ACTIVE   = 4'd6;
  localparam logic [3:0] DEF_BACKWARD = 4'd2;

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_HITSTUN   = 2'd1,
    ST_BLOCKSTUN = 2'd2,
    ST_KO        = 2'd3
  } stun_e;

  stun_e                  stun_q;
  logic                   connected;
  logic signed [GW-1:0]   gap_c;
  logic signed [GW-1:0]   reach_c;
  logic                   in_range_c;
  logic                   atk_active_c;
  logic                   contact_c;
  logic                   blocked_c;
  logic [HPW-1:0]         health_dec_c;
  logic [STUNW-1:0]       hit_load_c;
  logic [STUNW-1:0]       block_load_c;

  // Signed gap between attacker front edge and defender left edge; overlap counts as in range.
  always_comb begin
    gap_c        = $signed({1'b0, atk_x});
    reach_c      = atk_dir ? $signed(GW'(REACH_D)) : $signed(GW'(REACH_N));
    in_range_c   = 1'b0;
    gap_c        = $signed({1'b0, def_x}) - $signed({1'b0, atk_x}) - $signed(GW'(SPRITE_W));
    in_range_c   = (gap_c < 0) || (gap_c <= reach_c);
  end

  always_comb begin
    atk_active_c = (atk_state == ATK_ACTIVE);
    contact_c    = play_active && atk_active_c && in_range_c && !connected && (stun_q != ST_KO);
    blocked_c    = ((def_state == DEF_BACKWARD) || (stun_q == ST_BLOCKSTUN)) && (stun_q != ST_HITSTUN);
    health_dec_c = (health == '0) ? '0 : health - HPW'(1);
    hit_load_c   = atk_dir ? STUNW'(HITSTUN_D)   : STUNW'(HITSTUN_N);
    block_load_c = atk_dir ? STUNW'(BLOCKSTUN_D) : STUNW'(BLOCKSTUN_N);
  end

  // Defender stun FSM, health and pulses; contact has priority over the countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      stun_q      <= ST_NORMAL;
      stun_left   <= '0;
      health      <= HPW'(HEALTH_INIT);
      ko          <= 1'b0;
      hit_pulse   <= 1'b0;
      block_pulse <= 1'b0;
      connected   <= 1'b0;
    end else begin
      hit_pulse   <= 1'b0;
      block_pulse <= 1'b0;

      if (!atk_active_c) begin
        connected <= 1'b0;
      end else if (contact_c) begin
        connected <= 1'b1;
      end

      if (contact_c) begin
        if (blocked_c) begin
          block_pulse <= 1'b1;
          stun_q      <= ST_BLOCKSTUN;
          stun_left   <= block_load_c;
        end else begin
          hit_pulse <= 1'b1;
          health    <= health_dec_c;
          if (health_dec_c == '0) begin
            stun_q    <= ST_KO;
            stun_left <= '0;
            ko        <= 1'b1;
          end else begin
            stun_q    <= ST_HITSTUN;
            stun_left <= hit_load_c;
          end
        end
      end else if ((stun_q == ST_HITSTUN) || (stun_q == ST_BLOCKSTUN)) begin
        if (stun_left > STUNW'(1)) begin
          stun_left <= stun_left - STUNW'(1);
        end else begin
          stun_q    <= ST_NORMAL;
          stun_left <= '0;
        end
      end
    end
  end

  assign def_stun = stun_q;

`ifdef HIT_RESOLVER_COMBO_EN
  logic hit_expire_c;

  always_comb begin
    hit_expire_c = !contact_c && (stun_q == ST_HITSTUN) && (stun_left <= STUNW'(1));
  end

  // Consecutive unblocked hits landed while the defender is still in hitstun.
  always_ff @(posedge clk) begin
    if (reset) begin
      combo_count <= '0;
    end else if (contact_c && !blocked_c) begin
      if (stun_q == ST_HITSTUN) begin
        if (combo_count != '1) begin
          combo_count <= combo_count + CW'(1);
        end
      end else begin
        combo_count <= CW'(1);
      end
    end else if (hit_expire_c) begin
      combo_count <= '0;
    end
  end
`else
  assign combo_count = '0;
`endif

endmodule

// File: tb/tb_hit_resolver.sv
// Directed self-checking bench for hit_resolver: range, block, one-hit-per-phase, refresh, KO and reset.
module tb_hit_resolver;

  logic       clk;
  logic       reset;
  logic       play_active;
  logic [3:0] atk_state;
  logic       atk_dir;
  logic [9:0] atk_x;
  logic [9:0] def_x;
  logic [3:0] def_state;
  logic       hit_pulse;
  logic       block_pulse;
  logic [1:0] def_stun;
  logic [4:0] stun_left;
  logic [1:0] health;
  logic       ko;
  logic [3:0] combo_count;

  int total = 0;
  int bad   = 0;

  hit_resolver dut (
    .clk         (clk),
    .reset       (reset),
    .play_active (play_active),
    .atk_state   (atk_state),
    .atk_dir     (atk_dir),
    .atk_x       (atk_x),
    .def_x       (def_x),
    .def_state   (def_state),
    .hit_pulse   (hit_pulse),
    .block_pulse (block_pulse),
    .def_stun    (def_stun),
    .stun_left   (stun_left),
    .health      (health),
    .ko          (ko),
    .combo_count (combo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    atk_state = 4'd0;
    def_state = 4'd0;
    atk_dir   = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    play_active = 1'b1;
    atk_state   = 4'd0;
    atk_dir     = 1'b0;
    atk_x       = 10'd100;
    def_x       = 10'd190;
    def_state   = 4'd0;
    step();
    step();
    reset = 1'b0;

    check("rst_hit", 32'(hit_pulse), 32'd0);
    check("rst_block", 32'(block_pulse), 32'd0);
    check("rst_stun", 32'(def_stun), 32'd0);
    check("rst_left", 32'(stun_left), 32'd0);
    check("rst_health", 32'(health), 32'd3);
    check("rst_ko", 32'(ko), 32'd0);
    check("rst_combo", 32'(combo_count), 32'd0);

    // Neutral hit at gap 26
    atk_state = 4'd6;
    step();
    check("t1_hit", 32'(hit_pulse), 32'd1);
    check("t1_stun", 32'(def_stun), 32'd1);
    check("t1_left", 32'(stun_left), 32'd12);
    check("t1_health", 32'(health), 32'd2);
    atk_state = 4'd0;
    step();
    check("t1_pulse_drop", 32'(hit_pulse), 32'd0);
    check("t1_left_dec", 32'(stun_left), 32'd11);
    for (int i = 0; i < 10; i++) step();
    check("t1_last_left", 32'(stun_left), 32'd1);
    check("t1_last_stun", 32'(def_stun), 32'd1);
    step();
    check("t1_normal", 32'(def_stun), 32'd0);
    check("t1_zero", 32'(stun_left), 32'd0);

    // Gap 36: neutral misses, directional hits
    do_reset();
    def_x     = 10'd200;
    atk_state = 4'd6;
    step();
    check("t2_n_miss", 32'(hit_pulse), 32'd0);
    check("t2_n_stun", 32'(def_stun), 32'd0);
    atk_state = 4'd0;
    step();
    atk_state = 4'd6;
    atk_dir   = 1'b1;
    step();
    check("t2_d_hit", 32'(hit_pulse), 32'd1);
    check("t2_d_left", 32'(stun_left), 32'd15);
    check("t2_d_health", 32'(health), 32'd2);

    // Blocked directional attack
    do_reset();
    def_x     = 10'd200;
    def_state = 4'd2;
    atk_dir   = 1'b1;
    atk_state = 4'd6;
    step();
    check("t3_block", 32'(block_pulse), 32'd1);
    check("t3_hit", 32'(hit_pulse), 32'd0);
    check("t3_stun", 32'(def_stun), 32'd2);
    check("t3_left", 32'(stun_left), 32'd10);
    check("t3_health", 32'(health), 32'd3);

    // Reach boundary: gap 32 hits, gap 33 misses, overlap hits
    do_reset();
    def_x     = 10'd196;
    atk_state = 4'd6;
    step();
    check("bnd_32_hit", 32'(hit_pulse), 32'd1);
    do_reset();
    def_x     = 10'd197;
    atk_state = 4'd6;
    step();
    check("bnd_33_miss", 32'(hit_pulse), 32'd0);
    do_reset();
    def_x     = 10'd120;
    atk_state = 4'd6;
    step();
    check("bnd_overlap_hit", 32'(hit_pulse), 32'd1);

    // One hit per active phase, then refresh on a new phase
    do_reset();
    def_x     = 10'd190;
    atk_state = 4'd6;
    step();
    check("t4_first", 32'(hit_pulse), 32'd1);
    step();
    check("t4_no_repeat", 32'(hit_pulse), 32'd0);
    check("t4_countdown", 32'(stun_left), 32'd11);
    atk_state = 4'd7;
    step();
    check("t4_recover_left", 32'(stun_left), 32'd10);
    atk_state = 4'd6;
    step();
    check("t4_second", 32'(hit_pulse), 32'd1);
    check("t4_reload", 32'(stun_left), 32'd12);
    check("t4_health", 32'(health), 32'd1);
`ifdef HIT_RESOLVER_COMBO_EN
    check("t4_combo", 32'(combo_count), 32'd2);
`else
    check("t4_combo", 32'(combo_count), 32'd0);
`endif
    // Reset mid-stun
    atk_state = 4'd0;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_stun", 32'(def_stun), 32'd0);
    check("mid_rst_left", 32'(stun_left), 32'd0);
    check("mid_rst_health", 32'(health), 32'd3);

    // Three hits reach KO
    for (int i = 0; i < 3; i++) begin
      atk_state = 4'd6;
      step();
      check("t5_hit", 32'(hit_pulse), 32'd1);
      atk_state = 4'd0;
      step();
    end
    check("t5_health", 32'(health), 32'd0);
    check("t5_stun", 32'(def_stun), 32'd3);
    check("t5_ko", 32'(ko), 32'd1);
    check("t5_left", 32'(stun_left), 32'd0);
    atk_state = 4'd6;
    step();
    check("t5_ko_nohit", 32'(hit_pulse), 32'd0);
    check("t5_ko_noblock", 32'(block_pulse), 32'd0);
    check("t5_ko_sticky", 32'(def_stun), 32'd3);
    do_reset();
    check("t5_rst_health", 32'(health), 32'd3);
    check("t5_rst_ko", 32'(ko), 32'd0);

    // Round inactive ignores contact
    play_active = 1'b0;
    atk_state   = 4'd6;
    step();
    check("t6_nohit", 32'(hit_pulse), 32'd0);
    check("t6_health", 32'(health), 32'd3);
    check("t6_stun", 32'(def_stun), 32'd0);
    atk_state = 4'd0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
